// File: rtl/ldq_violation_scan.sv
// Load-queue order-violation scanner: a store-address CAM hit vector is filtered,
// then the oldest younger load is picked and held as a pending violation until acked.
`ifndef STRUCT_PARTS_LSQ
`define STRUCT_PARTS_LSQ 4
`endif

module ldq_violation_scan #(
    parameter int DEPTH     = 16,
    parameter int INDEX     = 4,
    parameter int NUM_PARTS = `STRUCT_PARTS_LSQ
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 searchValid_i,
    input  logic [DEPTH-1:0]     vect_i,
    input  logic [INDEX-1:0]     storeLdqPtr_i,
    input  logic [INDEX-1:0]     ldqHead_i,
    input  logic [INDEX-1:0]     ldqTail_i,
    input  logic                 ldqFull_i,
    input  logic [DEPTH-1:0]     ldqValid_i,
    input  logic [DEPTH-1:0]     ldqExecuted_i,
    input  logic [NUM_PARTS-1:0] lsqPartitionActive_i,
    input  logic                 recoverFlag_i,
    input  logic                 violateAck_i,
    output logic                 violateValid_o,
    output logic [INDEX-1:0]     violateIdx_o,
    output logic [15:0]          violateCnt_o
);

    localparam int PART_SIZE = DEPTH / NUM_PARTS;
    localparam int SPAN_W    = INDEX + 1;

    logic [DEPTH-1:0]  w_part_mask;
    logic              r_s1_valid;
    logic [DEPTH-1:0]  r_s1_elig;
    logic [INDEX-1:0]  r_s1_ptr;
    logic [INDEX-1:0]  r_s1_tail;
    logic              r_s1_full;
    logic [INDEX-1:0]  w_span_raw;
    logic [SPAN_W-1:0] w_span;
    logic              w_hit;
    logic [INDEX-1:0]  w_sel;
    logic [INDEX-1:0]  w_e;
    logic              w_s2_hit;
    logic [INDEX-1:0]  w_new_age;
    logic [INDEX-1:0]  w_pend_age;
    logic              w_load;
    logic              r_viol_valid;
    logic [INDEX-1:0]  r_viol_idx;
    logic [15:0]       r_cnt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_part
        assign w_part_mask[g] = lsqPartitionActive_i[g / PART_SIZE];
    end

    always_ff @(posedge clk) begin
        if (reset || recoverFlag_i) begin
            r_s1_valid <= 1'b0;
            r_s1_elig  <= '0;
        end else begin
            r_s1_valid <= searchValid_i;
            if (searchValid_i) begin
                r_s1_elig <= vect_i & ldqValid_i & ldqExecuted_i & w_part_mask;
                r_s1_ptr  <= storeLdqPtr_i;
                r_s1_tail <= ldqTail_i;
                r_s1_full <= ldqFull_i;
            end
        end
    end

    // A full queue with tail == store pointer means every entry is younger.
    assign w_span_raw = r_s1_tail - r_s1_ptr;
    assign w_span     = (w_span_raw == '0 && r_s1_full) ? SPAN_W'(DEPTH) : {1'b0, w_span_raw};

    // Walk from the youngest offset down so the smallest offset wins.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        w_e   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_e = r_s1_ptr + INDEX'(k);
            if ((SPAN_W'(k) < w_span) && r_s1_elig[w_e]) begin
                w_hit = 1'b1;
                w_sel = w_e;
            end
        end
    end

    assign w_s2_hit   = r_s1_valid & w_hit;
    assign w_new_age  = w_sel - ldqHead_i;
    assign w_pend_age = r_viol_idx - ldqHead_i;
    assign w_load     = w_s2_hit & (~r_viol_valid | violateAck_i | (w_new_age < w_pend_age));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_viol_valid <= 1'b0;
            r_viol_idx   <= '0;
            r_cnt        <= '0;
        end else if (recoverFlag_i) begin
            r_viol_valid <= 1'b0;
            r_viol_idx   <= '0;
        end else begin
            if (w_s2_hit && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_load) begin
                r_viol_valid <= 1'b1;
                r_viol_idx   <= w_sel;
            end else if (violateAck_i) begin
                r_viol_valid <= 1'b0;
            end
        end
    end

    assign violateValid_o = r_viol_valid;
    assign violateIdx_o   = r_viol_idx;
    assign violateCnt_o   = r_cnt;

endmodule

// File: tb/tb_ldq_violation_scan.sv
// Bench for ldq_violation_scan: directed spec scenarios followed by random traffic,
// each cycle compared against a queue-order reference model.
module tb_ldq_violation_scan;

    localparam int DEPTH     = 16;
    localparam int INDEX     = 4;
    localparam int NUM_PARTS = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 searchValid_i;
    logic [DEPTH-1:0]     vect_i;
    logic [INDEX-1:0]     storeLdqPtr_i;
    logic [INDEX-1:0]     ldqHead_i;
    logic [INDEX-1:0]     ldqTail_i;
    logic                 ldqFull_i;
    logic [DEPTH-1:0]     ldqValid_i;
    logic [DEPTH-1:0]     ldqExecuted_i;
    logic [NUM_PARTS-1:0] lsqPartitionActive_i;
    logic                 recoverFlag_i;
    logic                 violateAck_i;
    logic                 violateValid_o;
    logic [INDEX-1:0]     violateIdx_o;
    logic [15:0]          violateCnt_o;

    int checks   = 0;
    int failures = 0;

    bit m_pipe_v;
    int m_pipe_idx;
    bit m_v;
    int m_idx;
    int m_cnt;

    always #5 clk = ~clk;

    ldq_violation_scan #(.DEPTH(DEPTH), .INDEX(INDEX), .NUM_PARTS(NUM_PARTS)) dut (
        .clk                  (clk),
        .reset                (reset),
        .searchValid_i        (searchValid_i),
        .vect_i               (vect_i),
        .storeLdqPtr_i        (storeLdqPtr_i),
        .ldqHead_i            (ldqHead_i),
        .ldqTail_i            (ldqTail_i),
        .ldqFull_i            (ldqFull_i),
        .ldqValid_i           (ldqValid_i),
        .ldqExecuted_i        (ldqExecuted_i),
        .lsqPartitionActive_i (lsqPartitionActive_i),
        .recoverFlag_i        (recoverFlag_i),
        .violateAck_i         (violateAck_i),
        .violateValid_o       (violateValid_o),
        .violateIdx_o         (violateIdx_o),
        .violateCnt_o         (violateCnt_o)
    );

    // Oldest younger eligible load for one search, or -1.
    function automatic int find_violation(input int ptr, input int tail, input bit full,
                                          input logic [15:0] vect, input logic [15:0] vld,
                                          input logic [15:0] exe, input logic [3:0] act);
        int span;
        int best;
        int bestd;
        int d;
        span  = (tail - ptr + DEPTH) % DEPTH;
        if (span == 0 && full) span = DEPTH;
        best  = -1;
        bestd = DEPTH;
        for (int e = 0; e < DEPTH; e++) begin
            if (vect[e] && vld[e] && exe[e] && act[e / (DEPTH / NUM_PARTS)]) begin
                d = (e - ptr + DEPTH) % DEPTH;
                if (d < span && d < bestd) begin
                    bestd = d;
                    best  = e;
                end
            end
        end
        return best;
    endfunction

    task automatic model_update();
        int r;
        int head;
        head = int'(ldqHead_i);
        if (reset) begin
            m_pipe_v = 1'b0;
            m_v      = 1'b0;
            m_idx    = 0;
            m_cnt    = 0;
        end else if (recoverFlag_i) begin
            m_pipe_v = 1'b0;
            m_v      = 1'b0;
            m_idx    = 0;
        end else begin
            if (m_pipe_v) begin
                if (m_cnt < 65535) m_cnt++;
                if (!m_v || violateAck_i ||
                    ((m_pipe_idx - head + DEPTH) % DEPTH) < ((m_idx - head + DEPTH) % DEPTH)) begin
                    m_v   = 1'b1;
                    m_idx = m_pipe_idx;
                end
            end else if (violateAck_i) begin
                m_v = 1'b0;
            end
            r = searchValid_i ? find_violation(int'(storeLdqPtr_i), int'(ldqTail_i), ldqFull_i,
                                               vect_i, ldqValid_i, ldqExecuted_i,
                                               lsqPartitionActive_i) : -1;
            m_pipe_v   = (r >= 0);
            m_pipe_idx = r;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        model_update();
        #1;
        if (chk) begin
            check("valid", 32'(violateValid_o), 32'(m_v));
            if (m_v) check("idx", 32'(violateIdx_o), 32'(m_idx));
            check("cnt", 32'(violateCnt_o), 32'(m_cnt));
        end
    endtask

    task automatic search(input int ptr, input int tail, input bit full, input logic [15:0] v);
        searchValid_i = 1'b1;
        storeLdqPtr_i = INDEX'(ptr);
        ldqTail_i     = INDEX'(tail);
        ldqFull_i     = full;
        vect_i        = v;
    endtask

    task automatic pulse_ack();
        violateAck_i = 1'b1;
        step(1);
        violateAck_i = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        searchValid_i        = 1'b0;
        vect_i               = '0;
        storeLdqPtr_i        = '0;
        ldqHead_i            = '0;
        ldqTail_i            = '0;
        ldqFull_i            = 1'b0;
        ldqValid_i           = '1;
        ldqExecuted_i        = '1;
        lsqPartitionActive_i = '1;
        recoverFlag_i        = 1'b0;
        violateAck_i         = 1'b0;
        m_pipe_v = 1'b0; m_pipe_idx = 0; m_v = 1'b0; m_idx = 0; m_cnt = 0;

        step(0);
        step(1);
        check("rst_valid", 32'(violateValid_o), 32'd0);
        check("rst_idx",   32'(violateIdx_o),   32'd0);
        check("rst_cnt",   32'(violateCnt_o),   32'd0);
        reset = 1'b0;

        // Basic: entries 5 and 8 younger, 5 is oldest.
        search(3, 9, 1'b0, 16'h0120);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("basic_valid", 32'(violateValid_o), 32'd1);
        check("basic_idx",   32'(violateIdx_o),   32'd5);
        check("basic_cnt",   32'(violateCnt_o),   32'd1);
        pulse_ack();
        check("ack_clear", 32'(violateValid_o), 32'd0);

        // Wrap-around window.
        search(14, 2, 1'b0, 16'h8002);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("wrap_idx", 32'(violateIdx_o), 32'd15);
        pulse_ack();
        search(14, 14, 1'b1, 16'h2000);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("full_valid", 32'(violateValid_o), 32'd1);
        check("full_idx",   32'(violateIdx_o),   32'd13);
        pulse_ack();

        // Partition 1 (entries 4..7) powered off.
        lsqPartitionActive_i = 4'b1101;
        search(3, 9, 1'b0, 16'h0020);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("part_valid", 32'(violateValid_o), 32'd0);
        check("part_cnt",   32'(violateCnt_o),   32'd3);
        lsqPartitionActive_i = 4'b1111;

        // Replacement relative to head=2.
        ldqHead_i = 4'd2;
        search(6, 10, 1'b0, 16'h0080);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("pend7_idx", 32'(violateIdx_o), 32'd7);
        search(3, 9, 1'b0, 16'h0010);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("repl4_idx", 32'(violateIdx_o), 32'd4);
        search(8, 12, 1'b0, 16'h0200);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("keep4_idx", 32'(violateIdx_o), 32'd4);
        pulse_ack();
        check("ack_only_valid", 32'(violateValid_o), 32'd0);

        // Ack and a younger new violation land together.
        search(2, 8, 1'b0, 16'h0008);
        step(1);
        searchValid_i = 1'b0;
        step(1);
        check("pend3_idx", 32'(violateIdx_o), 32'd3);
        search(5, 9, 1'b0, 16'h0040);
        step(1);
        searchValid_i = 1'b0;
        violateAck_i  = 1'b1;
        step(1);
        violateAck_i  = 1'b0;
        check("ackload_valid", 32'(violateValid_o), 32'd1);
        check("ackload_idx",   32'(violateIdx_o),   32'd6);
        pulse_ack();

        // Flush with a search in flight.
        search(3, 9, 1'b0, 16'h0120);
        step(1);
        searchValid_i = 1'b0;
        recoverFlag_i = 1'b1;
        step(1);
        recoverFlag_i = 1'b0;
        check("recover_valid", 32'(violateValid_o), 32'd0);
        step(1);
        check("recover_after", 32'(violateValid_o), 32'd0);

        // Saturation: one detection per cycle for more than 0x10000 cycles.
        search(3, 9, 1'b0, 16'h0120);
        violateAck_i = 1'b1;
        for (int i = 0; i < 65536 + 4; i++) step(0);
        step(1);
        check("sat_cnt", 32'(violateCnt_o), 32'hFFFF);
        violateAck_i = 1'b0;
        step(1);
        check("sat_hold", 32'(violateCnt_o), 32'hFFFF);
        check("pend_before_rst", 32'(violateValid_o), 32'd1);
        reset = 1'b1;
        step(1);
        check("midrst_valid", 32'(violateValid_o), 32'd0);
        check("midrst_idx",   32'(violateIdx_o),   32'd0);
        check("midrst_cnt",   32'(violateCnt_o),   32'd0);
        reset = 1'b0;
        searchValid_i = 1'b0;
        step(1);
        check("rst_search_none1", 32'(violateValid_o), 32'd0);
        step(1);
        check("rst_search_none2", 32'(violateValid_o), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            reset                = ($urandom_range(0, 199) == 0);
            recoverFlag_i        = ($urandom_range(0, 49) == 0);
            searchValid_i        = ($urandom_range(0, 3) != 0);
            vect_i               = 16'($urandom);
            ldqValid_i           = 16'($urandom) | 16'($urandom);
            ldqExecuted_i        = 16'($urandom) | 16'($urandom);
            lsqPartitionActive_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            storeLdqPtr_i        = 4'($urandom);
            ldqTail_i            = 4'($urandom);
            ldqHead_i            = 4'($urandom);
            ldqFull_i            = ($urandom_range(0, 3) == 0);
            violateAck_i         = ($urandom_range(0, 2) == 0);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldq_violation_scan.md
LDQ_VIOLATION_SCAN -- requirements
Module: ldq_violation_scan

Interface
REQ-001 SHALL have parameter DEPTH, default 16: load-queue entry count (power of two).
REQ-002 SHALL have parameter INDEX, default 4: log2(DEPTH).
REQ-003 SHALL have parameter NUM_PARTS, default `STRUCT_PARTS_LSQ: LSQ partition count; each partition owns DEPTH/NUM_PARTS contiguous entries.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port searchValid_i, input, 1: a store-address CAM search result is present this cycle.
REQ-007 SHALL have port vect_i, input, DEPTH: per-entry address-match vector from the LDQ CAM.
REQ-008 SHALL have port storeLdqPtr_i, input, INDEX: LDQ tail captured at store dispatch (first younger load).
REQ-009 SHALL have port ldqHead_i / ldqTail_i, input, INDEX each: current LDQ head and tail.
REQ-010 SHALL have port ldqFull_i, input, 1: LDQ full.
REQ-011 SHALL have port ldqValid_i / ldqExecuted_i, input, DEPTH each: entry allocated / load has executed.
REQ-012 SHALL have port lsqPartitionActive_i, input, NUM_PARTS: partition power-on mask.
REQ-013 SHALL have port recoverFlag_i, input, 1: pipeline flush.
REQ-014 SHALL have port violateAck_i, input, 1: consumer accepts the pending violation.
REQ-015 SHALL have port violateValid_o, output, 1: a load-order violation is pending.
REQ-016 SHALL have port violateIdx_o, output, INDEX: LDQ index of the pending violating load.
REQ-017 SHALL have port violateCnt_o, output, 16: saturating count of violations detected.

Function
REQ-018 Stage 1 SHALL register eligible = vect_i & ldqValid_i & ldqExecuted_i & partition mask (entry e masked off when lsqPartitionActive_i[e/(DEPTH/NUM_PARTS)]==0), plus storeLdqPtr_i, ldqTail_i, ldqFull_i, when searchValid_i; otherwise stage-1 valid SHALL clear.
REQ-019 Stage 2 SHALL compute d(e)=(e-storeLdqPtr) mod DEPTH and span=(tail-storeLdqPtr) mod DEPTH, span=DEPTH when span==0 and full; entry e SHALL be younger iff d(e)<span.
REQ-020 Stage 2 SHALL select the eligible, younger entry with minimum d(e) (oldest younger load); none selected means no violation.
REQ-021 A violation found from a search in cycle N SHALL appear on violateValid_o/violateIdx_o in cycle N+2 (registered output).
REQ-022 While pending and not acked, a new violation SHALL replace the pending one only if older relative to head, i.e. (new-ldqHead_i) mod DEPTH < (pending-ldqHead_i) mod DEPTH; otherwise pending is kept.
REQ-023 violateValid_o SHALL hold with violateIdx_o stable until violateAck_i is sampled high; ack with no new violation SHALL clear valid next cycle.
REQ-024 Ack and a new violation in the same cycle SHALL load the new violation, valid staying high.
REQ-025 violateAck_i while violateValid_o==0 SHALL be ignored.
REQ-026 recoverFlag_i SHALL clear both pipeline stages and the pending violation next cycle, overriding any simultaneous search, ack or new violation.
REQ-027 violateCnt_o SHALL increment by 1 per stage-2 violation detected (including replaced or superseded ones), saturating at 16'hFFFF.
REQ-028 searchValid_i SHALL be accepted every cycle (fully pipelined, no back-pressure).

Reset
REQ-029 With reset high at a clock edge, violateValid_o, violateIdx_o, violateCnt_o and both stage valids SHALL be 0 next cycle.
REQ-030 reset SHALL override recoverFlag_i, searches and acks; a search during reset SHALL produce no violation.

Verification
REQ-031 DEPTH=16, all parts active, storePtr=3, tail=9, vect=0x0120 (entries 5, 8), valid/executed all ones, search cycle 0 -> cycle 2 valid=1, idx=5, cnt=1.
REQ-032 Wrap: storePtr=14, tail=2, vect bits 1 and 15 set -> idx=15; same with tail=14, full=1, vect bit 13 only -> idx=13.
REQ-033 Partition gating: NUM_PARTS=4, active=4'b1101, vect bit 5 only, younger and executed -> no violation, cnt unchanged.
REQ-034 Pending idx=7, head=2; new violation idx=4 without ack -> idx becomes 4; new violation idx=9 -> idx stays 4; ack alone -> valid=0 next cycle.
REQ-035 Pending valid, same cycle ack + new violation idx=6 -> valid stays 1, idx=6; recoverFlag_i with search in flight -> valid=0 and no output two cycles later.
REQ-036 Assert reset mid-operation with pending violation and cnt=0xFFFF -> all outputs 0 next cycle; 0x10000 detections without reset saturate cnt at 0xFFFF.
